gf8_reduce_seq: RTL and testbench

- Sequential reduction stage that sits directly downstream of the 8-bit carry-less multiplier slices.
- Combines the high product slice (bits 14:7) and the low slice (bits 6:0) into the 15-bit polynomial product.
- Reduces the product modulo a degree-8 field polynomial, one bit per cycle, and returns the GF(2^8) result.
- Valid/ready handshakes on both sides let it sit between the combinational multiplier and a consumer that may stall.

---
 rtl/gf8_reduce_seq.sv | 116 +++++++++++
 tb/tb_gf8_reduce_seq.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gf8_reduce_seq.sv
// Bit-serial GF(2^8) reduction of a 15-bit carry-less product, one product bit per cycle.
// Valid/ready on both sides; a result sits in DONE until the consumer takes it.
module gf8_reduce_seq #(
  parameter logic [8:0] POLY = 9'h11B
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] prod_hi,
  input  logic [6:0] prod_lo,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       busy
);

  generate
    if (POLY[8] != 1'b1) begin : g_bad_poly
      $error("gf8_reduce_seq: POLY must be a degree-8 polynomial (bit 8 set)");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_REDUCE,
    S_DONE
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [14:0] r_work, w_work_nxt;
  logic [3:0]  r_k, w_k_nxt;
  logic        r_out_valid, w_out_valid_nxt;
  logic [7:0]  r_out_data, w_out_data_nxt;

  logic [14:0] w_poly_sh;
  logic [14:0] w_step;
  logic        w_xfer;
  logic        w_accept;

  // A DONE result leaving this cycle frees the slot for a same-edge accept.
  assign w_xfer    = (r_state == S_DONE) && out_ready;
  assign in_ready  = rst_n && ((r_state == S_IDLE) || w_xfer);
  assign w_accept  = in_valid && in_ready;

  assign w_poly_sh = 15'(POLY) << (r_k - 4'd8);
  assign w_step    = r_work[r_k] ? (r_work ^ w_poly_sh) : r_work;

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = (r_state == S_REDUCE);

  always_comb begin
    w_state_nxt     = r_state;
    w_work_nxt      = r_work;
    w_k_nxt         = r_k;
    w_out_valid_nxt = r_out_valid;
    w_out_data_nxt  = r_out_data;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_work_nxt  = {prod_hi, prod_lo};
          w_k_nxt     = 4'd14;
          w_state_nxt = S_REDUCE;
        end
      end

      S_REDUCE: begin
        w_work_nxt = w_step;
        w_k_nxt    = r_k - 4'd1;
        // Bit 8 is the last one that can exceed the field degree.
        if (r_k == 4'd8) begin
          w_state_nxt     = S_DONE;
          w_out_valid_nxt = 1'b1;
          w_out_data_nxt  = w_step[7:0];
        end
      end

      S_DONE: begin
        if (w_xfer) begin
          w_out_valid_nxt = 1'b0;
          if (in_valid) begin
            w_work_nxt  = {prod_hi, prod_lo};
            w_k_nxt     = 4'd14;
            w_state_nxt = S_REDUCE;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end

      default: begin
        w_state_nxt     = S_IDLE;
        w_out_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_work      <= 15'd0;
      r_k         <= 4'd14;
      r_out_valid <= 1'b0;
      r_out_data  <= 8'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_work      <= w_work_nxt;
      r_k         <= w_k_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_data_nxt;
    end
  end

endmodule

// File: tb/tb_gf8_reduce_seq.sv
// Directed vectors, handshake corner cases and a random sweep for gf8_reduce_seq,
// with one instance on the AES polynomial and one on 0x11D sharing the same stimulus.
module tb_gf8_reduce_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] prod_hi = 8'd0;
  logic [6:0] prod_lo = 7'd0;

  logic       in_readyA, out_validA, busyA;
  logic [7:0] out_dataA;
  logic       in_readyB, out_validB, busyB;
  logic [7:0] out_dataB;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gf8_reduce_seq #(.POLY(9'h11B)) dutA (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_readyA),
    .prod_hi(prod_hi), .prod_lo(prod_lo), .out_valid(out_validA),
    .out_ready(out_ready), .out_data(out_dataA), .busy(busyA)
  );

  gf8_reduce_seq #(.POLY(9'h11D)) dutB (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_readyB),
    .prod_hi(prod_hi), .prod_lo(prod_lo), .out_valid(out_validB),
    .out_ready(out_ready), .out_data(out_dataB), .busy(busyB)
  );

  typedef struct {
    logic [7:0] hi;
    logic [6:0] lo;
    logic [7:0] expA;
    logic       checkB;
    logic [7:0] expB;
  } vec_t;

  vec_t vecs[6];

  // Shift-and-add field multiply, independent of the long-division reduction in the design.
  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b, input logic [8:0] poly);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'd0;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      y = y >> 1;
      if (x[7]) x = (x << 1) ^ poly[7:0];
      else      x = x << 1;
    end
    return p;
  endfunction

  function automatic logic [14:0] clMul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] r;
    r = 15'd0;
    for (int i = 0; i < 8; i++)
      if (b[i]) r = r ^ (15'(a) << i);
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic stepCycle;
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [7:0] hi, input logic [6:0] lo, input logic rdy);
    in_valid  = 1'b1;
    prod_hi   = hi;
    prod_lo   = lo;
    out_ready = rdy;
    #1;
  endtask

  // Starts in IDLE, pushes one pair, waits for the result and drains it.
  task automatic runOne(input logic [7:0] hi, input logic [6:0] lo,
                        output logic [7:0] gotA, output logic [7:0] gotB,
                        output int edges, output int busyCnt, output logic readyAtAccept);
    applyStimulus(hi, lo, 1'b1);
    readyAtAccept = in_readyA;
    stepCycle();
    in_valid = 1'b0;
    prod_hi  = ~hi;
    prod_lo  = ~lo;
    edges    = 0;
    busyCnt  = 0;
    while (!out_validA && edges < 20) begin
      if (busyA) busyCnt++;
      stepCycle();
      edges++;
    end
    gotA = out_dataA;
    gotB = out_dataB;
    stepCycle();
  endtask

  initial begin
    logic [7:0] gotA, gotB;
    logic       rdy;
    int         edges, busyCnt, readyHighs, validHighs;

    vecs[0] = '{hi: 8'h56, lo: 7'h79, expA: 8'hC1, checkB: 1'b0, expB: 8'h00};
    vecs[1] = '{hi: 8'h02, lo: 7'h00, expA: 8'h1B, checkB: 1'b1, expB: 8'h1D};
    vecs[2] = '{hi: 8'h00, lo: 7'h55, expA: 8'h55, checkB: 1'b1, expB: 8'h55};
    vecs[3] = '{hi: 8'h00, lo: 7'h00, expA: 8'h00, checkB: 1'b1, expB: 8'h00};
    vecs[4] = '{hi: 8'h01, lo: 7'h7F, expA: 8'hFF, checkB: 1'b1, expB: 8'hFF};
    vecs[5] = '{hi: 8'h80, lo: 7'h00, expA: 8'h9A, checkB: 1'b0, expB: 8'h00};

    // Reset state, both while held and after release
    #3;
    checkOutput("rst_out_valid", 16'(out_validA), 16'd0);
    checkOutput("rst_out_data", 16'(out_dataA), 16'h00);
    checkOutput("rst_in_ready", 16'(in_readyA), 16'd0);
    checkOutput("rst_busy", 16'(busyA), 16'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    stepCycle();
    checkOutput("idle_in_ready", 16'(in_readyA), 16'd1);
    checkOutput("idle_out_valid", 16'(out_validA), 16'd0);
    checkOutput("idle_out_data", 16'(out_dataA), 16'h00);
    checkOutput("idle_busy", 16'(busyA), 16'd0);

    // Directed table
    for (int i = 0; i < 6; i++) begin
      runOne(vecs[i].hi, vecs[i].lo, gotA, gotB, edges, busyCnt, rdy);
      checkOutput($sformatf("vec%0d_ready", i), 16'(rdy), 16'd1);
      checkOutput($sformatf("vec%0d_latency", i), 16'(edges), 16'd7);
      checkOutput($sformatf("vec%0d_busy_cycles", i), 16'(busyCnt), 16'd7);
      checkOutput($sformatf("vec%0d_dataA", i), 16'(gotA), 16'(vecs[i].expA));
      if (vecs[i].checkB)
        checkOutput($sformatf("vec%0d_dataB", i), 16'(gotB), 16'(vecs[i].expB));
      checkOutput($sformatf("vec%0d_idle_after", i), 16'(out_validA), 16'd0);
    end

    // Back-to-back with in_valid held high
    applyStimulus(8'h56, 7'h79, 1'b1);
    checkOutput("b2b_ready_first", 16'(in_readyA), 16'd1);
    stepCycle();
    prod_hi = 8'h02;
    prod_lo = 7'h00;
    edges = 0;
    readyHighs = 0;
    while (!out_validA && edges < 20) begin
      if (in_readyA) readyHighs++;
      stepCycle();
      edges++;
    end
    checkOutput("b2b_latency1", 16'(edges), 16'd7);
    checkOutput("b2b_ready_in_reduce", 16'(readyHighs), 16'd0);
    checkOutput("b2b_data1", 16'(out_dataA), 16'hC1);
    checkOutput("b2b_ready_on_xfer", 16'(in_readyA), 16'd1);
    stepCycle();
    in_valid = 1'b0;
    checkOutput("b2b_valid_drop", 16'(out_validA), 16'd0);
    checkOutput("b2b_busy_again", 16'(busyA), 16'd1);
    edges = 0;
    while (!out_validA && edges < 20) begin
      stepCycle();
      edges++;
    end
    checkOutput("b2b_latency2", 16'(edges), 16'd7);
    checkOutput("b2b_data2", 16'(out_dataA), 16'h1B);
    checkOutput("b2b_data2_B", 16'(out_dataB), 16'h1D);
    stepCycle();
    checkOutput("b2b_idle_after", 16'(out_validA), 16'd0);

    // Consumer stall in DONE
    applyStimulus(8'h56, 7'h79, 1'b0);
    stepCycle();
    in_valid = 1'b0;
    edges = 0;
    while (!out_validA && edges < 20) begin
      stepCycle();
      edges++;
    end
    checkOutput("stall_latency", 16'(edges), 16'd7);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        in_valid = 1'b1;
        prod_hi  = 8'h02;
        prod_lo  = 7'h00;
        #1;
      end
      checkOutput($sformatf("stall%0d_valid", i), 16'(out_validA), 16'd1);
      checkOutput($sformatf("stall%0d_data", i), 16'(out_dataA), 16'hC1);
      checkOutput($sformatf("stall%0d_in_ready", i), 16'(in_readyA), 16'd0);
      stepCycle();
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    #1;
    checkOutput("stall_release_ready", 16'(in_readyA), 16'd1);
    stepCycle();
    checkOutput("stall_valid_after", 16'(out_validA), 16'd0);
    checkOutput("stall_data_held", 16'(out_dataA), 16'hC1);
    checkOutput("stall_busy_after", 16'(busyA), 16'd0);
    validHighs = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_validA || busyA) validHighs++;
      stepCycle();
    end
    checkOutput("stall_single_xfer", 16'(validHighs), 16'd0);

    // Reset asserted mid-REDUCE
    applyStimulus(8'h02, 7'h00, 1'b1);
    stepCycle();
    in_valid = 1'b0;
    repeat (3) stepCycle();
    checkOutput("midrst_busy_before", 16'(busyA), 16'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", 16'(out_validA), 16'd0);
    checkOutput("midrst_busy", 16'(busyA), 16'd0);
    checkOutput("midrst_in_ready", 16'(in_readyA), 16'd0);
    checkOutput("midrst_out_data", 16'(out_dataA), 16'h00);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    validHighs = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_validA) validHighs++;
      stepCycle();
    end
    checkOutput("midrst_no_result", 16'(validHighs), 16'd0);
    checkOutput("midrst_idle_ready", 16'(in_readyA), 16'd1);

    // Random sweep against the shift-and-add reference for both polynomials
    for (int n = 0; n < 3000 && errors < 50; n++) begin
      logic [7:0]  a, b;
      logic [14:0] p;
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      p = clMul(a, b);
      runOne(p[14:7], p[6:0], gotA, gotB, edges, busyCnt, rdy);
      checkOutput($sformatf("rand%0d_latency", n), 16'(edges), 16'd7);
      checkOutput($sformatf("rand%0d_A_%0h_%0h", n, a, b), 16'(gotA), 16'(gfMul(a, b, 9'h11B)));
      checkOutput($sformatf("rand%0d_B_%0h_%0h", n, a, b), 16'(gotB), 16'(gfMul(a, b, 9'h11D)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
